// File: rtl/imem_boot_loader_if.sv
// Byte-stream loader bus: upstream byte handshake plus instruction-memory write port and core status.
// master: stream source / observer (drives start, byte_in, byte_valid).
// slave:  the loader (drives byte_ready, imem write port, core_rst, done, error).
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              done;
  logic              error;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, imem_we, imem_waddr, imem_wdata, core_rst, done, error
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, imem_we, imem_waddr, imem_wdata, core_rst, done, error
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: assembles LE 32-bit words from a length-prefixed, XOR-checksummed byte stream into imem.
// Latency: imem write one cycle after the 4th byte of a word; done/core_rst release one cycle after the checksum byte.
// Backpressure: byte_ready decodes from state only (high in LEN0/LEN1/DATA/CSUM); source may stall indefinitely.
// Ports: i_clk, i_rst (sync, active-high); bus (slave modport): start, byte_in/byte_valid/byte_ready,
//        imem_we/imem_waddr/imem_wdata, core_rst, done, error.
module imem_boot_loader #(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  imem_boot_loader_if.slave  bus
);

  // One extra bit so the counter can represent N == IMEM_DEPTH == 2**ADDR_W.
  localparam int                 CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0]   CNT_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_len_lo;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_idx;
  logic [7:0]        r_xor;
  logic [23:0]       r_word;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;

  logic              w_byte_ready;
  logic              w_acc;
  logic [15:0]       w_len;
  logic              w_len_bad;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_last_word;

  assign w_acc       = bus.byte_valid && w_byte_ready;
  assign w_len       = {bus.byte_in, r_len_lo};
  // Compare in 17 bits so a depth of 65536 would still be representable.
  assign w_len_bad   = (w_len == 16'd0) || ({1'b0, w_len} > 17'(IMEM_DEPTH));
  assign w_cnt_inc   = r_cnt + CNT_ONE;
  assign w_last_word = (w_cnt_inc == r_len);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and byte_ready; byte_ready is a pure state decode.
  always_comb begin
    w_next       = r_state;
    w_byte_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_LEN0;
      end
      S_LEN0: begin
        w_byte_ready = 1'b1;
        if (bus.byte_valid) w_next = S_LEN1;
      end
      S_LEN1: begin
        w_byte_ready = 1'b1;
        if (bus.byte_valid) w_next = w_len_bad ? S_ERR : S_DATA;
      end
      S_DATA: begin
        w_byte_ready = 1'b1;
        if (bus.byte_valid && (r_idx == 2'd3) && w_last_word) w_next = S_CSUM;
      end
      S_CSUM: begin
        w_byte_ready = 1'b1;
        if (bus.byte_valid) w_next = (bus.byte_in == r_xor) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        w_next = S_DONE;
      end
      S_ERR: begin
        if (bus.start) w_next = S_LEN0;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: length, byte assembly, running checksum, write port.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len_lo <= 8'd0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_idx    <= 2'd0;
      r_xor    <= 8'd0;
      r_word   <= 24'd0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= 32'd0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_ERR: begin
          if (bus.start) begin
            r_len_lo <= 8'd0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_idx    <= 2'd0;
            r_xor    <= 8'd0;
          end
        end
        S_LEN0: begin
          if (w_acc) r_len_lo <= bus.byte_in;
        end
        S_LEN1: begin
          // Only meaningful when the length passes the bound check, where it fits CNT_W.
          if (w_acc) r_len <= w_len[CNT_W-1:0];
        end
        S_DATA: begin
          if (w_acc) begin
            r_xor <= r_xor ^ bus.byte_in;
            r_idx <= r_idx + 2'd1;
            case (r_idx)
              2'd0: r_word[7:0]   <= bus.byte_in;
              2'd1: r_word[15:8]  <= bus.byte_in;
              2'd2: r_word[23:16] <= bus.byte_in;
              default: begin
                // Last byte of the word goes straight into the write data.
                r_we    <= 1'b1;
                r_waddr <= r_cnt[ADDR_W-1:0];
                r_wdata <= {bus.byte_in, r_word};
                r_cnt   <= w_cnt_inc;
              end
            endcase
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.byte_ready = w_byte_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_waddr = r_waddr;
  assign bus.imem_wdata = r_wdata;
  assign bus.done       = (r_state == S_DONE);
  assign bus.error      = (r_state == S_ERR);
  assign bus.core_rst   = (r_state != S_DONE);

endmodule
